// File: rtl/axonerve_kvs_stream_hub.sv
// axonerve_kvs_stream_hub
// Stream hub between the KVS kernel read-master output stream and the
// write-master input stream. It routes read data to user logic (mode 0),
// loops it back (modes 1 and 3), or adds a constant to every lane (mode 2).
// Write-side data is buffered in a first-word-fall-through FIFO. The hub
// also generates the kernel done pulse and keeps per-run beat counters.
//
// Ports
//   aclk, areset          clock, asynchronous active-high reset
//   ctrl_start            run start pulse; latches ctrl_mode / ctrl_constant
//   ctrl_mode             0 user, 1 loopback, 2 lane add, 3 loopback
//   ctrl_constant         per-lane addend used by mode 2
//   ctrl_read_done        read master completion pulse
//   ctrl_write_done       write master completion pulse
//   ctrl_done, ctrl_busy  one-cycle completion pulse, run-in-progress flag
//   stat_rd_beats         s_axis handshakes in the current/last run
//   stat_wr_beats         m_axis handshakes in the current/last run
//   s_axis_*              stream from the read master
//   u_rd_*                stream to user logic (mode 0)
//   u_wr_*                stream from user logic (mode 0)
//   m_axis_*              stream to the write master (FIFO head)
module axonerve_kvs_stream_hub #(
  parameter int C_DATA_WIDTH = 512,
  parameter int C_LANE_WIDTH = 32,
  parameter int C_FIFO_DEPTH = 16,
  parameter int C_CNT_WIDTH  = 32
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    ctrl_start,
  input  logic [1:0]              ctrl_mode,
  input  logic [C_LANE_WIDTH-1:0] ctrl_constant,
  input  logic                    ctrl_read_done,
  input  logic                    ctrl_write_done,
  output logic                    ctrl_done,
  output logic                    ctrl_busy,
  output logic [C_CNT_WIDTH-1:0]  stat_rd_beats,
  output logic [C_CNT_WIDTH-1:0]  stat_wr_beats,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  input  logic [C_DATA_WIDTH-1:0] s_axis_tdata,
  output logic                    u_rd_tvalid,
  input  logic                    u_rd_tready,
  output logic                    u_rd_tlast,
  output logic [C_DATA_WIDTH-1:0] u_rd_tdata,
  input  logic                    u_wr_tvalid,
  output logic                    u_wr_tready,
  input  logic [C_DATA_WIDTH-1:0] u_wr_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [C_DATA_WIDTH-1:0] m_axis_tdata
);

  localparam int PTR_W = $clog2(C_FIFO_DEPTH);
  localparam int LANES = C_DATA_WIDTH / C_LANE_WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                    state, state_nxt;
  logic [1:0]                mode_r;
  logic [C_LANE_WIDTH-1:0]   const_r;
  logic                      rd_seen, wr_seen;
  logic [PTR_W:0]            wr_ptr, rd_ptr;
  logic [C_DATA_WIDTH-1:0]   mem [C_FIFO_DEPTH];
  logic                      fifo_empty, fifo_full, fifo_wr, fifo_rd;
  logic [C_DATA_WIDTH-1:0]   fifo_din;
  logic                      run, user_mode, s_hs;

  // Lane-wise modular add; each lane wraps on its own so no carry leaks.
  function automatic logic [C_DATA_WIDTH-1:0] lane_add(
    input logic [C_DATA_WIDTH-1:0] d,
    input logic [C_LANE_WIDTH-1:0] k
  );
    logic [C_DATA_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++)
      r[i*C_LANE_WIDTH +: C_LANE_WIDTH] = d[i*C_LANE_WIDTH +: C_LANE_WIDTH] + k;
    return r;
  endfunction

  // Saturating increment: the counter sticks at all-ones.
  function automatic logic [C_CNT_WIDTH-1:0] sat_inc(input logic [C_CNT_WIDTH-1:0] c);
    return (&c) ? c : c + C_CNT_WIDTH'(1);
  endfunction

  assign run       = (state == RUN);
  assign user_mode = (mode_r == 2'd0);

  assign s_axis_tready = run && (user_mode ? u_rd_tready : !fifo_full);
  assign u_rd_tvalid   = run && user_mode && s_axis_tvalid;
  assign u_rd_tdata    = (run && user_mode) ? s_axis_tdata : '0;
  assign u_rd_tlast    = run && user_mode && s_axis_tlast;
  assign u_wr_tready   = run && user_mode && !fifo_full;

  assign s_hs    = s_axis_tvalid && s_axis_tready;
  assign fifo_wr = user_mode ? (u_wr_tvalid && u_wr_tready) : s_hs;
  assign fifo_din = user_mode          ? u_wr_tdata :
                    (mode_r == 2'd2)   ? lane_add(s_axis_tdata, const_r) :
                                         s_axis_tdata;

  // Wrap bit distinguishes full from empty when the index bits match.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_empty ? '0 : mem[rd_ptr[PTR_W-1:0]];
  assign fifo_rd       = m_axis_tvalid && m_axis_tready;

  assign ctrl_done = (state == DONE);
  assign ctrl_busy = run;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ctrl_start) state_nxt = RUN;
      RUN:     if (rd_seen && wr_seen) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state         <= IDLE;
      mode_r        <= 2'd1;
      const_r       <= '0;
      rd_seen       <= 1'b0;
      wr_seen       <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      stat_rd_beats <= '0;
      stat_wr_beats <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && ctrl_start) begin
        mode_r        <= ctrl_mode;
        const_r       <= ctrl_constant;
        rd_seen       <= 1'b0;
        wr_seen       <= 1'b0;
        stat_rd_beats <= '0;
        stat_wr_beats <= '0;
      end else if (run) begin
        if (ctrl_read_done)  rd_seen <= 1'b1;
        if (ctrl_write_done) wr_seen <= 1'b1;
        if (s_hs)            stat_rd_beats <= sat_inc(stat_rd_beats);
        if (fifo_rd)         stat_wr_beats <= sat_inc(stat_wr_beats);
      end
      if (fifo_wr) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (fifo_rd) rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  // FIFO storage carries data only and is never reset.
  always_ff @(posedge aclk) begin
    if (fifo_wr) mem[wr_ptr[PTR_W-1:0]] <= fifo_din;
  end

endmodule

// File: tb/tb_axonerve_kvs_stream_hub.sv
module tb_axonerve_kvs_stream_hub;

  localparam int DW = 64;
  localparam int LW = 32;

  logic          aclk = 1'b0;
  logic          areset;
  logic          ctrl_start, ctrl_read_done, ctrl_write_done;
  logic [1:0]    ctrl_mode;
  logic [LW-1:0] ctrl_constant;
  logic          ctrl_done, ctrl_busy;
  logic [31:0]   stat_rd_beats, stat_wr_beats;
  logic          s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [DW-1:0] s_axis_tdata;
  logic          u_rd_tvalid, u_rd_tready, u_rd_tlast;
  logic [DW-1:0] u_rd_tdata;
  logic          u_wr_tvalid, u_wr_tready;
  logic [DW-1:0] u_wr_tdata;
  logic          m_axis_tvalid, m_axis_tready;
  logic [DW-1:0] m_axis_tdata;

  int tests_run = 0;
  int tests_failed = 0;
  int done_cnt = 0;
  int acc_cnt = 0;
  bit user_en = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW:0]   rd_q[$];

  always #5 aclk = ~aclk;

  axonerve_kvs_stream_hub #(
    .C_DATA_WIDTH(DW), .C_LANE_WIDTH(LW), .C_FIFO_DEPTH(16), .C_CNT_WIDTH(32)
  ) dut (
    .aclk(aclk), .areset(areset),
    .ctrl_start(ctrl_start), .ctrl_mode(ctrl_mode), .ctrl_constant(ctrl_constant),
    .ctrl_read_done(ctrl_read_done), .ctrl_write_done(ctrl_write_done),
    .ctrl_done(ctrl_done), .ctrl_busy(ctrl_busy),
    .stat_rd_beats(stat_rd_beats), .stat_wr_beats(stat_wr_beats),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tdata(s_axis_tdata),
    .u_rd_tvalid(u_rd_tvalid), .u_rd_tready(u_rd_tready),
    .u_rd_tlast(u_rd_tlast), .u_rd_tdata(u_rd_tdata),
    .u_wr_tvalid(u_wr_tvalid), .u_wr_tready(u_wr_tready), .u_wr_tdata(u_wr_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata)
  );

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void fail_now(input string name);
    tests_run++;
    tests_failed++;
    $display("FAIL %s", name);
  endfunction

  // Monitor: compares every output handshake against the scoreboards.
  always @(negedge aclk) begin
    logic [DW:0] e;
    if (ctrl_done === 1'b1) done_cnt++;
    if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
      if (exp_q.size() == 0) fail_now("m_axis_unexpected_word");
      else check("m_axis_data", m_axis_tdata, exp_q.pop_front());
    end
    if (u_rd_tvalid === 1'b1 && u_rd_tready === 1'b1) begin
      if (rd_q.size() == 0) fail_now("u_rd_unexpected_word");
      else begin
        e = rd_q.pop_front();
        check("u_rd_data", u_rd_tdata, e[DW-1:0]);
        check("u_rd_tlast", 64'(u_rd_tlast), 64'(e[DW]));
      end
    end
  end

  // User-logic read-side backpressure, random while enabled.
  initial begin
    u_rd_tready = 1'b0;
    forever begin
      @(posedge aclk);
      #1;
      u_rd_tready = user_en ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "simulation time limit");
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic start_run(input logic [1:0] mode, input logic [31:0] k);
    ctrl_start = 1'b1; ctrl_mode = mode; ctrl_constant = k;
    cycles(1);
    ctrl_start = 1'b0;
  endtask

  task automatic pulse_done(input bit r, input bit w);
    ctrl_read_done = r; ctrl_write_done = w;
    cycles(1);
    ctrl_read_done = 1'b0; ctrl_write_done = 1'b0;
  endtask

  // One beat on s_axis; the expected m_axis word is queued once accepted.
  task automatic send(input logic [DW-1:0] d, input logic last, input bit push_m,
                      input logic [DW-1:0] exp_m, input bit push_rd);
    int t;
    t = 0;
    s_axis_tvalid = 1'b1; s_axis_tdata = d; s_axis_tlast = last;
    if (push_rd) rd_q.push_back({last, d});
    @(negedge aclk);
    while (s_axis_tready !== 1'b1 && t < 200) begin @(negedge aclk); t++; end
    @(posedge aclk);
    #1;
    if (t >= 200) fail_now("s_axis_accept_timeout");
    else begin
      acc_cnt++;
      if (push_m) exp_q.push_back(exp_m);
    end
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
  endtask

  task automatic user_send(input logic [DW-1:0] d);
    int t;
    t = 0;
    u_wr_tvalid = 1'b1; u_wr_tdata = d;
    @(negedge aclk);
    while (u_wr_tready !== 1'b1 && t < 200) begin @(negedge aclk); t++; end
    @(posedge aclk);
    #1;
    if (t >= 200) fail_now("u_wr_accept_timeout");
    else exp_q.push_back(d);
    u_wr_tvalid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid === 1'b1) && t < 300) begin cycles(1); t++; end
    if (t >= 300) fail_now(name);
  endtask

  task automatic wait_done(input int d0, input string name);
    int t;
    t = 0;
    while (done_cnt == d0 && t < 10) begin cycles(1); t++; end
    cycles(3);
    check(name, 64'(done_cnt - d0), 64'd1);
    check({name, "_busy"}, 64'(ctrl_busy), 64'd0);
  endtask

  initial begin
    int d0;
    areset = 1'b1;
    ctrl_start = 0; ctrl_mode = 0; ctrl_constant = 0;
    ctrl_read_done = 0; ctrl_write_done = 0;
    s_axis_tvalid = 0; s_axis_tlast = 0; s_axis_tdata = 0;
    u_wr_tvalid = 0; u_wr_tdata = 0; m_axis_tready = 0;
    cycles(3);
    check("rst_busy", 64'(ctrl_busy), 0);
    check("rst_done", 64'(ctrl_done), 0);
    check("rst_m_tvalid", 64'(m_axis_tvalid), 0);
    check("rst_m_tdata", m_axis_tdata, 0);
    check("rst_stat_rd", 64'(stat_rd_beats), 0);
    check("rst_stat_wr", 64'(stat_wr_beats), 0);
    areset = 1'b0;
    cycles(2);
    // Idle gating
    s_axis_tvalid = 1'b1;
    cycles(1);
    check("idle_s_tready", 64'(s_axis_tready), 0);
    check("idle_u_wr_tready", 64'(u_wr_tready), 0);
    check("idle_u_rd_tvalid", 64'(u_rd_tvalid), 0);
    s_axis_tvalid = 1'b0;

    // 1: loopback, 40 beats
    m_axis_tready = 1'b1;
    start_run(2'd1, 32'd0);
    check("t1_busy", 64'(ctrl_busy), 1);
    for (int i = 0; i < 40; i++)
      send({32'(100 + i), 32'(i)}, i == 39, 1, {32'(100 + i), 32'(i)}, 0);
    wait_drain("t1_drain_timeout");
    d0 = done_cnt;
    pulse_done(1, 0);
    pulse_done(0, 1);
    wait_done(d0, "t1_done_pulses");
    check("t1_stat_rd", 64'(stat_rd_beats), 40);
    check("t1_stat_wr", 64'(stat_wr_beats), 40);

    // 2: lane add, constant 1, wrap must not carry into the neighbour lane
    start_run(2'd2, 32'h0000_0001);
    send(64'h0000_0005_FFFF_FFFF, 0, 1, 64'h0000_0006_0000_0000, 0);
    send(64'hFFFF_FFFF_0000_0005, 0, 1, 64'h0000_0000_0000_0006, 0);
    send(64'h7FFF_FFFF_1234_5678, 1, 1, 64'h8000_0000_1234_5679, 0);
    wait_drain("t2_drain_timeout");
    d0 = done_cnt;
    pulse_done(1, 1);
    wait_done(d0, "t2_done_pulses");
    check("t2_stat_rd", 64'(stat_rd_beats), 3);

    // 3: backpressure fills the FIFO at 16 words
    m_axis_tready = 1'b0;
    acc_cnt = 0;
    start_run(2'd1, 32'd0);
    fork
      for (int i = 0; i < 20; i++)
        send({32'hB0B0_0000, 32'(i)}, i == 19, 1, {32'hB0B0_0000, 32'(i)}, 0);
      begin
        cycles(30);
        check("t3_accepted", 64'(acc_cnt), 16);
        check("t3_s_tready_full", 64'(s_axis_tready), 0);
        m_axis_tready = 1'b1;
      end
    join
    wait_drain("t3_drain_timeout");
    check("t3_stat_rd", 64'(stat_rd_beats), 20);
    check("t3_stat_wr", 64'(stat_wr_beats), 20);
    d0 = done_cnt;
    pulse_done(0, 1);
    pulse_done(1, 0);
    wait_done(d0, "t3_done_pulses");

    // 4: user mode with random handshakes
    start_run(2'd0, 32'd0);
    user_en = 1;
    fork
      for (int i = 0; i < 25; i++)
        send({32'h5A5A_0000, 32'(i * 3)}, i == 24, 0, 64'd0, 1);
      for (int i = 0; i < 25; i++) begin
        int gap;
        gap = $urandom_range(0, 2);
        if (gap > 0) cycles(gap);
        user_send({32'hC3C3_0000, 32'(i * 7)});
      end
    join
    user_en = 0;
    wait_drain("t4_drain_timeout");
    check("t4_rd_q_empty", 64'(rd_q.size()), 0);
    check("t4_stat_rd", 64'(stat_rd_beats), 25);
    check("t4_stat_wr", 64'(stat_wr_beats), 25);
    d0 = done_cnt;
    pulse_done(1, 1);
    wait_done(d0, "t4_done_pulses");

    // 5: done ordering, start during RUN, repeated read_done
    start_run(2'd1, 32'd0);
    for (int i = 0; i < 3; i++) send(64'(i + 1), 0, 1, 64'(i + 1), 0);
    wait_drain("t5_drain_timeout");
    start_run(2'd0, 32'd9);
    check("t5_start_ignored_cnt", 64'(stat_rd_beats), 3);
    check("t5_start_ignored_busy", 64'(ctrl_busy), 1);
    send(64'h44, 1, 1, 64'h44, 0);
    d0 = done_cnt;
    pulse_done(0, 1);
    cycles(4);
    check("t5_no_early_done", 64'(done_cnt - d0), 0);
    check("t5_still_busy", 64'(ctrl_busy), 1);
    pulse_done(1, 0);
    pulse_done(1, 0);
    wait_done(d0, "t5_done_pulses");
    check("t5_stat_rd", 64'(stat_rd_beats), 4);
    check("t5_stat_hold", 64'(stat_wr_beats), 4);
    // mode 3 behaves as loopback; both dones in the same cycle
    start_run(2'd3, 32'h10);
    send(64'hDEAD_BEEF_0000_0001, 0, 1, 64'hDEAD_BEEF_0000_0001, 0);
    send(64'h0123_4567_89AB_CDEF, 1, 1, 64'h0123_4567_89AB_CDEF, 0);
    wait_drain("t5b_drain_timeout");
    d0 = done_cnt;
    pulse_done(1, 1);
    pulse_done(1, 1);
    wait_done(d0, "t5b_done_pulses");

    // 6: asynchronous reset with 8 words buffered
    m_axis_tready = 1'b0;
    start_run(2'd1, 32'd0);
    for (int i = 0; i < 8; i++) send(64'(i + 50), 0, 0, 64'd0, 0);
    check("t6_words_held", 64'(m_axis_tvalid), 1);
    check("t6_stat_rd_pre", 64'(stat_rd_beats), 8);
    d0 = done_cnt;
    s_axis_tvalid = 1'b1;
    #2;
    areset = 1'b1;
    #1;
    check("t6_async_m_tvalid", 64'(m_axis_tvalid), 0);
    check("t6_async_m_tdata", m_axis_tdata, 0);
    check("t6_async_s_tready", 64'(s_axis_tready), 0);
    check("t6_async_busy", 64'(ctrl_busy), 0);
    check("t6_async_done", 64'(ctrl_done), 0);
    check("t6_async_stat_rd", 64'(stat_rd_beats), 0);
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    cycles(2);
    areset = 1'b0;
    cycles(3);
    check("t6_fifo_empty", 64'(m_axis_tvalid), 0);
    check("t6_no_done", 64'(done_cnt - d0), 0);
    start_run(2'd1, 32'd0);
    for (int i = 0; i < 5; i++) send(64'(i + 900), i == 4, 1, 64'(i + 900), 0);
    wait_drain("t6_drain_timeout");
    d0 = done_cnt;
    pulse_done(1, 1);
    wait_done(d0, "t6_done_pulses");
    check("t6_stat_wr", 64'(stat_wr_beats), 5);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/axonerve_kvs_stream_hub.md
Name: axonerve_kvs_stream_hub

Overview:
Configurable stream hub between the AXI4 read master output stream and the AXI4 write master input stream of the KVS kernel.
- Supports three runtime modes:
  - user-logic pass-through;
  - internal loopback;
  - per-lane constant add.
- Buffers write-side data in a first-word-fall-through (FWFT) FIFO.
- Produces the kernel done pulse from the read-master and write-master completion signals.
- Keeps per-run beat statistics.

Parameters:
C_DATA_WIDTH, 512, stream data width in bits; must be a multiple of C_LANE_WIDTH.
C_LANE_WIDTH, 32, adder lane width in bits.
C_FIFO_DEPTH, 16, write-side FIFO depth in entries; power of 2, minimum 2.
C_CNT_WIDTH, 32, width of the statistics counters.

Ports:
aclk  in  1  kernel clock; all logic is single-clock.
areset  in  1  reset, asynchronous, active-high.
ctrl_start  in  1  run start pulse (ap_start).
ctrl_mode  in  2  mode: 0 = user, 1 = loopback, 2 = add, 3 = reserved (behaves as 1); sampled on start.
ctrl_constant  in  C_LANE_WIDTH  addend for mode 2; sampled on start.
ctrl_read_done  in  1  read master completion pulse.
ctrl_write_done  in  1  write master completion pulse.
ctrl_done  out  1  one-cycle run completion pulse (ap_done).
ctrl_busy  out  1  high while the state is RUN.
stat_rd_beats  out  C_CNT_WIDTH  number of s_axis handshakes in the current/last run.
stat_wr_beats  out  C_CNT_WIDTH  number of m_axis handshakes in the current/last run.
s_axis_tvalid/tready/tlast  in/out/in  1 each  stream from the read master.
s_axis_tdata  in  C_DATA_WIDTH  read data.
u_rd_tvalid/tready/tlast  out/in/out  1 each  stream to user logic.
u_rd_tdata  out  C_DATA_WIDTH  data to user logic.
u_wr_tvalid/tready  in/out  1 each  stream from user logic.
u_wr_tdata  in  C_DATA_WIDTH  data from user logic.
m_axis_tvalid/tready  out/in  1 each  stream to the write master.
m_axis_tdata  out  C_DATA_WIDTH  write data.

Behaviour:
- Reset:
  - State returns to IDLE.
  - FIFO is emptied.
  - Mode register = 1; constant register = 0.
  - Sticky flags and counters cleared.
  - All valid, ready and done outputs = 0; data outputs = 0.
  - Reset mid-run aborts the run; no ctrl_done pulse is generated.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on ctrl_start. The same edge latches ctrl_mode and ctrl_constant, clears both counters and clears the sticky flags rd_seen and wr_seen.
  - ctrl_start outside IDLE is ignored.
  - In RUN: ctrl_read_done sets rd_seen and ctrl_write_done sets wr_seen. Both may arrive in the same cycle, in either order, or repeat.
  - RUN -> DONE in the cycle after rd_seen && wr_seen first holds.
  - DONE drives ctrl_done = 1 for exactly one cycle, then the FSM moves to IDLE.
- Input gating:
  - In IDLE and DONE: s_axis_tready = 0, u_wr_tready = 0, u_rd_tvalid = 0.
  - m_axis drains the FIFO in every state.
- Mode 0 (user):
  - u_rd_* is a combinational pass-through of s_axis: u_rd_tvalid = s_axis_tvalid, s_axis_tready = u_rd_tready, tdata/tlast pass straight through.
  - The u_wr stream writes the FIFO; u_wr_tready = !fifo_full.
- Mode 1/3 (loopback):
  - s_axis writes the FIFO; s_axis_tready = !fifo_full.
  - u_rd_tvalid = 0, u_wr_tready = 0.
- Mode 2 (add):
  - Same routing as mode 1.
  - Each C_LANE_WIDTH lane i of the written word = s_axis lane i + constant, modulo 2^C_LANE_WIDTH; carries never cross lanes.
  - The adder is combinational at the FIFO input and adds no latency.
- FIFO:
  - FWFT: m_axis_tvalid = !empty, m_axis_tdata = head entry.
  - A word written at clock edge N is visible on m_axis at N+1; write-to-output latency is 1 cycle.
  - Full at C_FIFO_DEPTH entries. Pointers are log2(depth)+1 bits with wrap bit.
  - Simultaneous read and write when full: write refused (tready already low), read proceeds.
  - Simultaneous read and write when empty: write accepted, no read.
  - No overflow or underflow is possible under handshake rules.
- tlast is not stored in the FIFO. The write master is length-driven.
- Counters:
  - stat_rd_beats increments on s_axis_tvalid && s_axis_tready.
  - stat_wr_beats increments on m_axis_tvalid && m_axis_tready.
  - Both saturate at all-ones and hold their value after the run until the next start.

Test Plan:
1. Mode 1: start, 40 beats of incrementing data with m_axis_tready = 1, then read_done and write_done -> 40 beats out, identical and in order; ctrl_done single pulse 1 cycle after the later done; both counters = 40.
2. Mode 2: constant = 0x0000_0001, lane values 0xFFFF_FFFF and 0x0000_0005 -> output lanes 0x0000_0000 and 0x0000_0006; the neighbouring lane is unaffected by the wrap carry.
3. Backpressure: mode 1, m_axis_tready = 0 for 30 cycles while s_axis is valid -> exactly 16 words accepted, s_axis_tready low from then on; release tready -> all words delivered, none lost or duplicated.
4. Mode 0: user loop with random u_rd_tready/u_wr_tvalid and 25 beats -> u_rd data equals s_axis data, m_axis data equals u_wr data; u_rd_tlast follows s_axis_tlast.
5. Done ordering: write_done before read_done, both in the same cycle, and a repeated read_done -> exactly one ctrl_done per run; ctrl_start during RUN ignored.
6. Reset mid-run: areset asserted with 8 words in the FIFO -> all outputs 0 immediately (asynchronously), FIFO empty after release, no ctrl_done; a new run then completes normally.
